// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and stage-count helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package shifter_pkg;

    // Operation select carried with every request through the pipeline.
    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRA = 2'b01,
        MODE_ROR = 2'b10,
        MODE_SRL = 2'b11
    } shift_mode_e;

    // Number of register stages needed for `layers` shift layers grouped `per_stage` at a time.
    function automatic int stage_count(input int layers, input int per_stage);
        return (layers + per_stage - 1) / per_stage;
    endfunction

    // One past the index of the last layer owned by `stage` (the final stage may be short).
    function automatic int stage_hi(input int layers, input int per_stage, input int stage);
        int hi;
        hi = (stage + 1) * per_stage;
        return (hi < layers) ? hi : layers;
    endfunction

endpackage

// File: rtl/shift_layer.sv
// One conditional shift-by-SHIFT layer of the barrel shifter, with running carry.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline stage decides when the result is captured.
//
// Ports:
//   data_in  - operand coming from the previous layer (or the stage input)
//   mode     - SLL / SRA / ROR / SRL
//   enable   - matching bit of the shift amount; when low the layer is transparent
//   carry_in - carry produced by earlier layers (0 at the first layer)
//   data_out - shifted operand
//   carry    - last bit shifted out by this layer, or carry_in when disabled
module shift_layer
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  shift_mode_e      mode,
    input  logic             enable,
    input  logic             carry_in,
    output logic [WIDTH-1:0] data_out,
    output logic             carry
);

    // The carry of the whole shift is the bit shifted out by the highest enabled
    // layer. Because earlier layers have already moved the operand by the lower
    // amount bits, the local "last bit out" here lines up with the bit position
    // the full shift amount would pick from the original operand.
    always_comb begin
        data_out = data_in;
        carry    = carry_in;
        if (enable) begin
            case (mode)
                MODE_SLL: begin
                    data_out = data_in << SHIFT;
                    carry    = data_in[WIDTH-SHIFT];
                end
                MODE_SRA: begin
                    data_out = $signed(data_in) >>> SHIFT;
                    carry    = data_in[SHIFT-1];
                end
                MODE_ROR: begin
                    data_out = {data_in[SHIFT-1:0], data_in[WIDTH-1:SHIFT]};
                    // Result MSB after rotation.
                    carry    = data_in[SHIFT-1];
                end
                MODE_SRL: begin
                    data_out = data_in >> SHIFT;
                    carry    = data_in[SHIFT-1];
                end
                default: begin
                    data_out = data_in;
                    carry    = carry_in;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SLL/SRA/ROR/SRL) with carry/zero flags and a sideband tag.
// Latency: NSTAGE = ceil(log2(WIDTH)/REG_EVERY) cycles from acceptance to out_valid.
// Backpressure: valid/ready; stages compress bubbles, in_ready drops only when stage 0 is held.
//
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   in_valid/in_ready             - request handshake
//   in_data, in_mode, in_amt      - operand, operation, shift amount
//   in_tag                        - opaque tag returned with the result
//   out_valid/out_ready           - result handshake
//   out_data, out_carry, out_zero - result and flags
//   out_tag                       - tag of the result
//   busy                          - any stage holds a request
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [1:0]               in_mode,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_carry,
    output logic                     out_zero,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     busy
);

    localparam int NLAYER = $clog2(WIDTH);
    localparam int NSTAGE = stage_count(NLAYER, REG_EVERY);

    // Per-stage result payload; mode and the not-yet-consumed amount bits travel
    // in separate per-stage registers whose width shrinks stage by stage.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             carry;
        logic [TAG_W-1:0] tag;
    } res_t;

    logic [NSTAGE-1:0] vld;
    logic [NSTAGE-1:0] adv;
    logic [NSTAGE-1:0] load;
    res_t              res_d [NSTAGE];
    res_t              res_q [NSTAGE];

    // ------------------------------------------------------------------
    // Datapath: each stage owns layers [LO, HI) and registers their output.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
        localparam int LO = k * REG_EVERY;
        localparam int HI = stage_hi(NLAYER, REG_EVERY, k);
        localparam int NL = HI - LO;

        res_t                  src;
        shift_mode_e           mode_src;
        logic [NLAYER-1:LO]    amt_src;
        logic [NL:0][WIDTH-1:0] lay_dat;
        logic [NL:0]           lay_cry;

        if (k == 0) begin : g_in
            // Carry starts at 0 so an all-zero amount yields carry 0.
            assign src      = '{data: in_data, carry: 1'b0, tag: in_tag};
            assign mode_src = shift_mode_e'(in_mode);
            assign amt_src  = in_amt;
        end else begin : g_link
            assign src      = res_q[k-1];
            assign mode_src = g_stg[k-1].g_ctl.mode_q;
            assign amt_src  = g_stg[k-1].g_ctl.amt_q;
        end

        assign lay_dat[0] = src.data;
        assign lay_cry[0] = src.carry;

        for (genvar l = 0; l < NL; l++) begin : g_lay
            shift_layer #(
                .WIDTH (WIDTH),
                .SHIFT (1 << (LO + l))
            ) u_layer (
                .data_in  (lay_dat[l]),
                .mode     (mode_src),
                .enable   (amt_src[LO+l]),
                .carry_in (lay_cry[l]),
                .data_out (lay_dat[l+1]),
                .carry    (lay_cry[l+1])
            );
        end

        assign res_d[k] = '{data: lay_dat[NL], carry: lay_cry[NL], tag: src.tag};

        // Control for the following stage; the last stage needs none.
        if (k < NSTAGE - 1) begin : g_ctl
            shift_mode_e        mode_q;
            logic [NLAYER-1:HI] amt_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mode_q <= MODE_SLL;
                    amt_q  <= '0;
                end else if (load[k]) begin
                    mode_q <= mode_src;
                    amt_q  <= amt_src[NLAYER-1:HI];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Flow control: a stage advances when downstream is empty or itself
    // advancing; evaluated from the output end so a full pipe can drain and
    // accept in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        logic nxt_open;
        nxt_open = out_ready;
        adv      = '0;
        load     = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            adv[k]   = vld[k] && nxt_open;
            nxt_open = !vld[k] || adv[k];
        end
        in_ready = !rst && nxt_open;
        load[0]  = in_valid && in_ready;
        for (int k = 1; k < NSTAGE; k++) begin
            load[k] = adv[k-1];
        end
    end

    // Payload registers only change on load, so a held stage keeps its
    // contents stable and un-accepted input cycles leave state untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSTAGE; k++) begin
                if (load[k]) begin
                    vld[k]   <= 1'b1;
                    res_q[k] <= res_d[k];
                end else if (adv[k]) begin
                    vld[k]   <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = vld[NSTAGE-1];
    assign out_data  = res_q[NSTAGE-1].data;
    assign out_carry = res_q[NSTAGE-1].carry;
    assign out_tag   = res_q[NSTAGE-1].tag;
    // Qualified by out_valid so the flag reads 0 out of reset.
    assign out_zero  = out_valid && (res_q[NSTAGE-1].data == '0);
    assign busy      = |vld;

endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width; power of two, 8..64.
REQ-002 SHALL have parameter REG_EVERY, default 2: shift layers per pipeline stage, 1..log2(WIDTH).
REQ-003 SHALL have parameter TAG_W, default 4: sideband tag width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1: request present.
REQ-007 SHALL have port in_ready, output, 1: request accepted when in_valid && in_ready.
REQ-008 SHALL have port in_data, input, WIDTH: operand.
REQ-009 SHALL have port in_mode, input, 2: 00 SLL, 01 SRA, 10 ROR, 11 SRL.
REQ-010 SHALL have port in_amt, input, log2(WIDTH): shift amount.
REQ-011 SHALL have port in_tag, input, TAG_W: opaque tag carried with the request.
REQ-012 SHALL have port out_valid, output, 1: result present.
REQ-013 SHALL have port out_ready, input, 1: result consumed when out_valid && out_ready.
REQ-014 SHALL have port out_data, output, WIDTH: result.
REQ-015 SHALL have port out_carry, output, 1: carry flag.
REQ-016 SHALL have port out_zero, output, 1: high when out_data == 0.
REQ-017 SHALL have port out_tag, output, TAG_W: tag of the result.
REQ-018 SHALL have port busy, output, 1: any pipeline stage valid.

Function
REQ-019 SHALL compute the shift as log2(WIDTH) conditional layers (amounts 1, 2, 4, ..., WIDTH/2), each enabled by the matching in_amt bit, LSB layer first.
REQ-020 SHALL register after every REG_EVERY layers (and after the last); NSTAGE = ceil(log2(WIDTH)/REG_EVERY); latency = NSTAGE cycles from acceptance to out_valid with no backpressure (16/2 gives 2).
REQ-021 SHALL fill vacated positions as follows: SLL with 0; SRA with the operand MSB; SRL with 0; ROR with bits rotated in from the LSB end.
REQ-022 SHALL set out_carry to in_data[WIDTH-amt] for SLL, in_data[amt-1] for SRA/SRL, and result MSB for ROR; out_carry SHALL be 0 when amt == 0 in every mode.
REQ-023 SHALL carry mode, remaining amount bits, carry state and tag with the data through each stage.
REQ-024 SHALL advance each stage when the next stage is empty or advancing in the same cycle; the last stage SHALL advance on out_ready.
REQ-025 SHALL drive in_ready = !stage0_valid || stage0_advances, giving one result per cycle throughput; accept and drain in the same cycle SHALL be legal when full.
REQ-026 SHALL hold out_data, out_carry, out_zero and out_tag stable while out_valid && !out_ready.
REQ-027 SHALL deliver results in acceptance order with no loss or duplication under any out_ready pattern.
REQ-028 SHALL ignore input fields when in_valid is low; no stage SHALL change on an un-accepted cycle.

Reset
REQ-029 SHALL on rst clear all stage valid bits, drive out_valid=0, busy=0, in_ready=0 and out_data/out_tag/out_carry/out_zero=0, asynchronously.
REQ-030 SHALL drop in-flight requests on reset mid-operation and produce no result for them.
REQ-031 SHALL drive in_ready=1 from the first clock edge after rst deassertion.

Structure
REQ-032 SHALL place mode encodings (MODE_SLL/SRA/ROR/SRL) in shared package shifter_pkg.
REQ-033 SHALL implement one layer as sub-module shift_layer (parameters WIDTH, SHIFT; inputs data, mode, enable, carry_in; outputs data, carry), instantiated log2(WIDTH) times.

Verification
REQ-034 SHALL verify, at defaults: SLL 0x8001 amt 1 -> out 0x0002, carry 1, zero 0, exactly 2 cycles after acceptance.
REQ-035 SHALL verify: SRA 0x8000 amt 15 -> 0xFFFF, carry 0; SRL 0x8000 amt 15 -> 0x0001, carry 0.
REQ-036 SHALL verify: ROR 0x1234 amt 4 -> 0x4123, carry 0; any mode with amt 0 -> data unchanged, carry 0.
REQ-037 SHALL verify: SRL 0x0001 amt 1 -> 0x0000, zero 1, carry 1.
REQ-038 SHALL verify: 4 back-to-back requests with tags 1..4 and out_ready=0 for 5 cycles -> in_ready low once 2 are held, outputs stable while held, then tags 1,2,3,4 delivered in order, one per cycle.
REQ-039 SHALL verify: rst asserted with 2 requests in flight -> out_valid and busy 0 immediately, neither result ever appears, and in_ready=1 after release.
